and_chk8bit: RTL and testbench

Self-checking response checker for the 8-bit bitwise-AND datapath of the Power ALU. It receives operand/result triples (a, b, out) from a stimulus source through a valid/ready handshake and compares each result against a locally computed a & b. It counts checked vectors and mismatches, and captures the first failing triple. It is the receiving end of the operand-driver interface and lets AND-unit regressions run in hardware, with no simulator-side monitor.

---
 rtl/and_chk8bit_if.sv | 34 +++
 rtl/and_chk8bit.sv | 178 +++++++++++++++++
 tb/tb_and_chk8bit.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/and_chk8bit_if.sv
// ---------------------------------------------------------------------------
// and_chk8bit_if
// Operand/result handshake between a stimulus source (master) and the
// AND-unit response checker (slave).
//   in_valid : master -> slave, triple on a/b/out is valid
//   in_ready : slave  -> master, checker accepts a triple this cycle
//   a, b     : master -> slave, operands applied to the unit under check
//   out      : master -> slave, result produced by the unit under check
// ---------------------------------------------------------------------------
interface and_chk8bit_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] out;

    modport master (
        output in_valid,
        output a,
        output b,
        output out,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  out,
        output in_ready
    );
endinterface

// File: rtl/and_chk8bit.sv
// ---------------------------------------------------------------------------
// and_chk8bit
// Response checker for the 8-bit bitwise-AND datapath. Accepts (a, b, out)
// triples over a valid/ready handshake, compares out against a & b, counts
// compared vectors and mismatches, and captures the first failing triple.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   start, num_vec      : run request and number of vectors for the run
//   bus (slave)         : in_valid/in_ready/a/b/out handshake
//   busy, done, pass    : run status (pass only meaningful in DONE)
//   vec_cnt, err_cnt    : vectors compared / mismatches (saturating)
//   fail_idx, fail_a, fail_b, fail_out, fail_exp, fail_vld : first failure
// ---------------------------------------------------------------------------
module and_chk8bit #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vec,
    and_chk8bit_if.slave     bus,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] fail_idx,
    output logic [WIDTH-1:0] fail_a,
    output logic [WIDTH-1:0] fail_b,
    output logic [WIDTH-1:0] fail_out,
    output logic [WIDTH-1:0] fail_exp,
    output logic             fail_vld
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    state_t           r_state;
    logic [CNT_W-1:0] r_num_vec;
    logic [CNT_W-1:0] r_acc_cnt;
    logic             r_vld_p1;
    logic [WIDTH-1:0] r_a_p1;
    logic [WIDTH-1:0] r_b_p1;
    logic [WIDTH-1:0] r_out_p1;
    logic [CNT_W-1:0] r_idx_p1;
    logic [CNT_W-1:0] r_vec_cnt;
    logic [CNT_W-1:0] r_err_cnt;
    logic [CNT_W-1:0] r_fail_idx;
    logic [WIDTH-1:0] r_fail_a;
    logic [WIDTH-1:0] r_fail_b;
    logic [WIDTH-1:0] r_fail_out;
    logic [WIDTH-1:0] r_fail_exp;
    logic             r_fail_vld;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;

    logic             w_xfer;
    logic [WIDTH-1:0] w_exp_p1;
    logic             w_mis_p1;
    logic [CNT_W-1:0] w_vec_next;
    logic [CNT_W-1:0] w_err_next;

    // Ready drops as soon as num_vec triples have been accepted, even while
    // the last ones are still draining through the compare stage.
    assign bus.in_ready = (r_state == ST_RUN) && (r_acc_cnt < r_num_vec);
    assign w_xfer       = bus.in_valid && bus.in_ready;

    assign w_exp_p1   = r_a_p1 & r_b_p1;
    assign w_mis_p1   = (w_exp_p1 != r_out_p1);
    assign w_vec_next = r_vec_cnt + CNT_W'(1);
    assign w_err_next = w_mis_p1 ? sat_inc(r_err_cnt) : r_err_cnt;

    // ---- stage 1: capture accepted triple and its index ----
    always_ff @(posedge clk) begin
        if (w_xfer) begin
            r_a_p1   <= bus.a;
            r_b_p1   <= bus.b;
            r_out_p1 <= bus.out;
            r_idx_p1 <= r_acc_cnt;
        end
    end

    // ---- stage 2: compare, count, first-failure capture; run FSM ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_num_vec  <= '0;
            r_acc_cnt  <= '0;
            r_vld_p1   <= 1'b0;
            r_vec_cnt  <= '0;
            r_err_cnt  <= '0;
            r_fail_idx <= '0;
            r_fail_a   <= '0;
            r_fail_b   <= '0;
            r_fail_out <= '0;
            r_fail_exp <= '0;
            r_fail_vld <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
        end else begin
            r_vld_p1 <= w_xfer;
            if (w_xfer) begin
                r_acc_cnt <= r_acc_cnt + CNT_W'(1);
            end

            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_num_vec  <= num_vec;
                        r_acc_cnt  <= '0;
                        r_vec_cnt  <= '0;
                        r_err_cnt  <= '0;
                        r_fail_vld <= 1'b0;
                        if (num_vec == '0) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= 1'b1;
                        end else begin
                            r_state <= ST_RUN;
                            r_busy  <= 1'b1;
                            r_done  <= 1'b0;
                            r_pass  <= 1'b0;
                        end
                    end
                end

                ST_RUN: begin
                    if (r_vld_p1) begin
                        r_vec_cnt <= w_vec_next;
                        r_err_cnt <= w_err_next;
                        if (w_mis_p1 && !r_fail_vld) begin
                            r_fail_vld <= 1'b1;
                            r_fail_idx <= r_idx_p1;
                            r_fail_a   <= r_a_p1;
                            r_fail_b   <= r_b_p1;
                            r_fail_out <= r_out_p1;
                            r_fail_exp <= w_exp_p1;
                        end
                        // Final compare: status and counts become visible together.
                        if (w_vec_next == r_num_vec) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (w_err_next == '0);
                        end
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign pass     = r_pass;
    assign vec_cnt  = r_vec_cnt;
    assign err_cnt  = r_err_cnt;
    assign fail_idx = r_fail_idx;
    assign fail_a   = r_fail_a;
    assign fail_b   = r_fail_b;
    assign fail_out = r_fail_out;
    assign fail_exp = r_fail_exp;
    assign fail_vld = r_fail_vld;

endmodule

// File: tb/tb_and_chk8bit.sv
// ---------------------------------------------------------------------------
// tb_and_chk8bit
// Directed and randomized stimulus for and_chk8bit, with expected results
// derived from the vector tables by plain counting in the bench.
// ---------------------------------------------------------------------------
module tb_and_chk8bit;
    localparam int WIDTH = 8;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [CNT_W-1:0] num_vec = '0;
    logic             busy, done, pass, fail_vld;
    logic [CNT_W-1:0] vec_cnt, err_cnt, fail_idx;
    logic [WIDTH-1:0] fail_a, fail_b, fail_out, fail_exp;

    and_chk8bit_if #(.WIDTH(WIDTH)) bus();

    and_chk8bit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .num_vec  (num_vec),
        .bus      (bus),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .vec_cnt  (vec_cnt),
        .err_cnt  (err_cnt),
        .fail_idx (fail_idx),
        .fail_a   (fail_a),
        .fail_b   (fail_b),
        .fail_out (fail_out),
        .fail_exp (fail_exp),
        .fail_vld (fail_vld)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [7:0] va [16];
    logic [7:0] vb [16];
    logic [7:0] vo [16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int k);
        bus.a   = va[k];
        bus.b   = vb[k];
        bus.out = vo[k];
    endtask

    task automatic do_start(input int nv);
        start   = 1'b1;
        num_vec = CNT_W'(nv);
        tick();
        start   = 1'b0;
    endtask

    // Sends vectors 0..n-1 (optionally with random idle gaps), then checks
    // that ready is gone after the last transfer and done follows one edge later.
    task automatic run_vecs(input int n, input bit gaps, input int budget, output int cycles);
        int k;
        int cyc;
        bit xfer;
        k   = 0;
        cyc = 0;
        load(0);
        bus.in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
        while (k < n && cyc < budget) begin
            xfer = bus.in_valid && bus.in_ready;
            tick();
            cyc++;
            if (xfer) begin
                k++;
                if (k < n) load(k);
            end
            if (k < n) bus.in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        bus.in_valid = 1'b0;
        cycles = cyc;
        chk("xfer_count", 32'(k), 32'(n));
        chk("ready_low_after_last", 32'(bus.in_ready), 32'd0);
        chk("done_low_at_last", 32'(done), 32'd0);
        tick();
        chk("done_after_last", 32'(done), 32'd1);
    endtask

    task automatic wait_done(input int budget);
        int c;
        c = 0;
        while (!done && c < budget) begin
            tick();
            c++;
        end
        chk("done_reached", 32'(done), 32'd1);
    endtask

    // Reference: count mismatches of out against a & b over the table.
    task automatic expect_results(input string tag, input int n);
        int e;
        int fi;
        e  = 0;
        fi = -1;
        for (int i = 0; i < n; i++) begin
            if ((va[i] & vb[i]) != vo[i]) begin
                e++;
                if (fi < 0) fi = i;
            end
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_vec_cnt"}, 32'(vec_cnt), 32'(n));
        chk({tag, "_err_cnt"}, 32'(err_cnt), 32'(e));
        chk({tag, "_pass"}, 32'(pass), (e == 0) ? 32'd1 : 32'd0);
        chk({tag, "_fail_vld"}, 32'(fail_vld), (e > 0) ? 32'd1 : 32'd0);
        if (e > 0) begin
            chk({tag, "_fail_idx"}, 32'(fail_idx), 32'(fi));
            chk({tag, "_fail_a"}, 32'(fail_a), 32'(va[fi]));
            chk({tag, "_fail_b"}, 32'(fail_b), 32'(vb[fi]));
            chk({tag, "_fail_out"}, 32'(fail_out), 32'(vo[fi]));
            chk({tag, "_fail_exp"}, 32'(fail_exp), 32'(va[fi] & vb[fi]));
        end
    endtask

    task automatic load_clean_table();
        logic [7:0] ta [8];
        logic [7:0] tb [8];
        logic [7:0] to [8];
        ta = '{8'hFF, 8'h00, 8'hFF, 8'h55, 8'h82, 8'h84, 8'h88, 8'h90};
        tb = '{8'h4A, 8'hFF, 8'h81, 8'hAA, 8'h1E, 8'h40, 8'h85, 8'h97};
        to = '{8'h4A, 8'h00, 8'h81, 8'h00, 8'h02, 8'h00, 8'h80, 8'h90};
        for (int i = 0; i < 8; i++) begin
            va[i] = ta[i];
            vb[i] = tb[i];
            vo[i] = to[i];
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int cnt;
        bit xfer;
        bit seen;
        int n;

        bus.in_valid = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        bus.out      = '0;

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_fail_vld", 32'(fail_vld), 32'd0);
        chk("rst_vec_cnt", 32'(vec_cnt), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        chk("rst_fail_idx", 32'(fail_idx), 32'd0);
        chk("rst_fail_a", 32'(fail_a), 32'd0);
        chk("rst_fail_b", 32'(fail_b), 32'd0);
        chk("rst_fail_out", 32'(fail_out), 32'd0);
        chk("rst_fail_exp", 32'(fail_exp), 32'd0);
        rst_n = 1'b1;
        tick();

        // Reset mid-run: two triples accepted, one still in flight
        do_start(4);
        chk("mid_busy", 32'(busy), 32'd1);
        chk("mid_in_ready", 32'(bus.in_ready), 32'd1);
        for (int i = 0; i < 2; i++) begin
            va[i] = 8'($urandom);
            vb[i] = 8'($urandom);
            vo[i] = 8'($urandom);
        end
        bus.in_valid = 1'b1;
        load(0);
        tick();
        load(1);
        tick();
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("async_rst_vec_cnt", 32'(vec_cnt), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_done", 32'(done), 32'd0);
        chk("post_rst_vec_cnt", 32'(vec_cnt), 32'd0);
        chk("post_rst_err_cnt", 32'(err_cnt), 32'd0);
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd0);
        va[0] = 8'h0F;
        vb[0] = 8'hF0;
        vo[0] = 8'h00;
        do_start(1);
        run_vecs(1, 1'b0, 20, cyc);
        expect_results("after_rst", 1);

        // Clean run, back-to-back
        load_clean_table();
        do_start(8);
        run_vecs(8, 1'b0, 50, cyc);
        chk("clean_no_bubbles", 32'(cyc), 32'd8);
        expect_results("clean", 8);

        // Injected faults; restart from DONE
        vo[3] = 8'h01;
        vo[6] = 8'h00;
        do_start(8);
        chk("restart_done_drop", 32'(done), 32'd0);
        chk("restart_busy", 32'(busy), 32'd1);
        chk("restart_pass_clr", 32'(pass), 32'd0);
        chk("restart_vec_clr", 32'(vec_cnt), 32'd0);
        run_vecs(8, 1'b0, 50, cyc);
        expect_results("inject", 8);
        chk("inject_fail_idx_lit", 32'(fail_idx), 32'd3);
        chk("inject_fail_out_lit", 32'(fail_out), 32'h01);

        // Backpressure: valid held for 5 cycles, only 2 accepted
        for (int i = 0; i < 3; i++) begin
            va[i] = 8'($urandom);
            vb[i] = 8'($urandom);
            vo[i] = va[i] & vb[i];
        end
        do_start(2);
        cnt = 0;
        load(0);
        bus.in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            xfer = bus.in_valid && bus.in_ready;
            tick();
            if (xfer) begin
                cnt++;
                load(cnt);
            end
        end
        chk("bp_xfers", 32'(cnt), 32'd2);
        chk("bp_ready_low", 32'(bus.in_ready), 32'd0);
        bus.in_valid = 1'b0;
        wait_done(20);
        expect_results("bp", 2);

        // Zero-length run
        do_start(0);
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_pass", 32'(pass), 32'd1);
        chk("zero_busy", 32'(busy), 32'd0);
        seen = bus.in_ready;
        bus.in_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (bus.in_ready) seen = 1'b1;
        end
        bus.in_valid = 1'b0;
        chk("zero_no_ready", 32'(seen), 32'd0);
        chk("zero_vec_cnt", 32'(vec_cnt), 32'd0);

        // Restart with a bad triple
        va[0] = 8'hFF;
        vb[0] = 8'hFF;
        vo[0] = 8'hFE;
        do_start(1);
        chk("zr_start_vec_clr", 32'(vec_cnt), 32'd0);
        chk("zr_start_err_clr", 32'(err_cnt), 32'd0);
        chk("zr_start_fvld_clr", 32'(fail_vld), 32'd0);
        run_vecs(1, 1'b0, 20, cyc);
        expect_results("zero_restart", 1);
        chk("zr_fail_exp_lit", 32'(fail_exp), 32'hFF);

        // Start during RUN is ignored
        for (int i = 0; i < 3; i++) begin
            va[i] = 8'($urandom);
            vb[i] = 8'($urandom);
            vo[i] = (i == 1) ? 8'($urandom) : (va[i] & vb[i]);
        end
        do_start(3);
        start   = 1'b1;
        num_vec = CNT_W'(1);
        tick();
        start   = 1'b0;
        chk("ign_busy", 32'(busy), 32'd1);
        chk("ign_ready", 32'(bus.in_ready), 32'd1);
        run_vecs(3, 1'b0, 30, cyc);
        expect_results("ignored_start", 3);

        // Randomized runs with idle gaps
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, 12);
            for (int i = 0; i < n; i++) begin
                va[i] = 8'($urandom);
                vb[i] = 8'($urandom);
                vo[i] = ($urandom_range(0, 1) == 1) ? (va[i] & vb[i]) : 8'($urandom);
            end
            do_start(n);
            run_vecs(n, 1'b1, 400, cyc);
            expect_results("random", n);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
